// File: rtl/sequenciador_ciclo_if.sv
// Memory request bus between the instruction sequencer and the memory.
// Handshake: mem_req and its qualifiers (mem_we, mem_addr, mem_wsrc) stay stable until a cycle with mem_ack=1 completes the request.
interface sequenciador_ciclo_if;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [1:0] mem_wsrc;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wsrc,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wsrc,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sequenciador_ciclo.sv
// Multi-cycle instruction sequencer: fetch, decode, optional memory access, retire.
// All outputs are registered; only the LDA/LDB load strobes are gated by mem_ack so they land in the ack cycle.
module sequenciador_ciclo (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       a_zero,
  sequenciador_ciclo_if.master       bus,
  output logic [1:0]                 alu_op,
  output logic                       a_we,
  output logic                       b_we,
  output logic [1:0]                 a_src,
  output logic [3:0]                 pc,
  output logic [7:0]                 ir,
  output logic                       busy,
  output logic                       instr_done,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDB = 4'd4;
  localparam logic [3:0] OP_STB = 4'd5;
  localparam logic [3:0] OP_LDC = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;

  state_t     state;
  logic       a_we_q;
  logic       ld_a;
  logic       ld_b;
  logic [3:0] op;
  logic [1:0] wsrc_dec;
  logic       we_dec;

  assign op        = ir[7:4];
  assign state_dbg = state;

  always_comb begin
    wsrc_dec = 2'b00;
    we_dec   = 1'b1;
    case (op)
      OP_ADD, OP_SUB: wsrc_dec = 2'b10;
      OP_STB:         wsrc_dec = 2'b01;
      OP_LDA, OP_LDB: we_dec   = 1'b0;
      default:        wsrc_dec = 2'b00;
    endcase
  end

  // Loads write their register in the very cycle the memory acks.
  assign a_we = a_we_q | (ld_a & bus.mem_ack);
  assign b_we = ld_b & bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= 4'd0;
      ir           <= 8'd0;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= 4'd0;
      bus.mem_wsrc <= 2'b00;
      alu_op       <= 2'b00;
      a_we_q       <= 1'b0;
      a_src        <= 2'b00;
      ld_a         <= 1'b0;
      ld_b         <= 1'b0;
      busy         <= 1'b0;
      instr_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state        <= FETCH;
            busy         <= 1'b1;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= pc;
          end
        end

        FETCH: begin
          if (bus.mem_ack) begin
            state        <= DECODE;
            ir           <= bus.mem_rdata;
            pc           <= pc + 4'd1;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= 4'd0;
            // LDC strobes during DECODE, so decode it from the incoming byte.
            if (bus.mem_rdata[7:4] == OP_LDC) begin
              a_we_q <= 1'b1;
              a_src  <= 2'b01;
            end
          end
        end

        DECODE: begin
          a_we_q <= 1'b0;
          a_src  <= 2'b00;
          if (op <= OP_STB) begin
            state        <= MEM;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= ir[3:0];
            bus.mem_we   <= we_dec;
            bus.mem_wsrc <= wsrc_dec;
            alu_op       <= (op == OP_SUB) ? 2'b01 : 2'b00;
            ld_a         <= (op == OP_LDA);
            ld_b         <= (op == OP_LDB);
          end else begin
            state      <= DONE;
            instr_done <= 1'b1;
            if (op == OP_JMP && a_zero) pc <= ir[3:0];
          end
        end

        MEM: begin
          if (bus.mem_ack) begin
            state        <= DONE;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= 4'd0;
            bus.mem_wsrc <= 2'b00;
            alu_op       <= 2'b00;
            ld_a         <= 1'b0;
            ld_b         <= 1'b0;
            instr_done   <= 1'b1;
          end
        end

        DONE: begin
          instr_done <= 1'b0;
          if (run) begin
            state        <= FETCH;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= pc;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_ciclo.sv
// Bench for sequenciador_ciclo: directed programs plus random instructions and ack delays,
// checked against an instruction-level model of pc, bus requests and register strobes.
module tb_sequenciador_ciclo;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       a_zero;
  logic [1:0] alu_op;
  logic       a_we;
  logic       b_we;
  logic [1:0] a_src;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       busy;
  logic       instr_done;
  logic [2:0] state_dbg;

  sequenciador_ciclo_if bus_if ();

  sequenciador_ciclo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .a_zero     (a_zero),
    .bus        (bus_if.master),
    .alu_op     (alu_op),
    .a_we       (a_we),
    .b_we       (b_we),
    .a_src      (a_src),
    .pc         (pc),
    .ir         (ir),
    .busy       (busy),
    .instr_done (instr_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pc_m     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory-phase expectations straight from the opcode table.
  function automatic void mem_expect(input int op, output logic we, output logic [1:0] wsrc,
                                     output logic [1:0] alu);
    we   = (op == 0 || op == 1 || op == 3 || op == 5);
    wsrc = (op <= 1) ? 2'd2 : (op == 5) ? 2'd1 : 2'd0;
    alu  = (op == 1) ? 2'd1 : 2'd0;
  endfunction

  // Runs one instruction; entered and left at a negedge with the block in FETCH.
  task automatic do_instr(input logic [7:0] instr, input int fw, input int mw, input logic az,
                          input logic drop, input logic rst_abort);
    int         op;
    int         imm;
    int         next_pc;
    logic       e_we;
    logic [1:0] e_wsrc;
    logic [1:0] e_alu;
    op      = int'(instr[7:4]);
    imm     = int'(instr[3:0]);
    next_pc = (op == 7 && az) ? imm : (pc_m + 1) % 16;

    for (int i = 0; i <= fw; i++) begin
      bus_if.mem_ack   = (i == fw);
      bus_if.mem_rdata = (i == fw) ? instr : 8'($urandom);
      #1;
      check("fetch_req",  bus_if.mem_req, 1);
      check("fetch_we",   bus_if.mem_we, 0);
      check("fetch_addr", bus_if.mem_addr, pc_m);
      check("fetch_busy", busy, 1);
      check("fetch_strb", {a_we, b_we, instr_done}, 0);
      if (drop && i == 0) run = 1'b0;
      @(negedge clk);
    end
    bus_if.mem_ack = 1'b0;

    check("dec_ir",   ir, instr);
    check("dec_pc",   pc, (pc_m + 1) % 16);
    check("dec_req",  bus_if.mem_req, 0);
    check("dec_a_we", a_we, (op == 6));
    check("dec_asrc", a_src, (op == 6) ? 1 : 0);
    check("dec_b_we", {b_we, instr_done}, 0);
    a_zero = az;
    @(negedge clk);
    a_zero = 1'($urandom);

    if (op <= 5) begin
      mem_expect(op, e_we, e_wsrc, e_alu);
      for (int i = 0; i <= mw; i++) begin
        bus_if.mem_ack   = (i == mw);
        bus_if.mem_rdata = 8'($urandom);
        #1;
        check("mem_req",  bus_if.mem_req, 1);
        check("mem_addr", bus_if.mem_addr, imm);
        check("mem_we",   bus_if.mem_we, e_we);
        check("mem_wsrc", bus_if.mem_wsrc, e_wsrc);
        check("mem_alu",  alu_op, e_alu);
        check("mem_a_we", a_we, (i == mw && op == 2));
        check("mem_b_we", b_we, (i == mw && op == 4));
        check("mem_asrc", a_src, 0);
        if (rst_abort && i == 1) begin
          bus_if.mem_ack = 1'b0;
          rst_n = 1'b0;
          #1;
          check("rst_req",  bus_if.mem_req, 0);
          check("rst_pc",   pc, 0);
          check("rst_busy", busy, 0);
          check("rst_ir",   ir, 0);
          check("rst_we",   {bus_if.mem_we, a_we, b_we, instr_done}, 0);
          return;
        end
        @(negedge clk);
      end
      bus_if.mem_ack = 1'b0;
    end

    check("done_pulse", instr_done, 1);
    check("done_req",   bus_if.mem_req, 0);
    check("done_strb",  {bus_if.mem_we, a_we, b_we}, 0);
    check("done_pc",    pc, next_pc);
    pc_m = next_pc;
    @(negedge clk);

    if (!run) begin
      for (int i = 0; i < 3; i++) begin
        check("idle_busy", busy, 0);
        check("idle_req",  bus_if.mem_req, 0);
        check("idle_done", instr_done, 0);
        @(negedge clk);
      end
      run = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    run              = 1'b0;
    a_zero           = 1'b0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 8'd0;
    #1;
    check("reset_outs", {bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wsrc,
                         alu_op, a_we, b_we, a_src, busy, instr_done}, 0);
    check("reset_pc_ir", {pc, ir}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_run", {bus_if.mem_req, busy}, 0);
    end
    run = 1'b1;
    @(negedge clk);

    // directed program
    do_instr(8'h65, 0, 0, 1'b0, 1'b0, 1'b0);  // LDC 5
    do_instr(8'h2A, 0, 3, 1'b0, 1'b0, 1'b0);  // LDA 10, slow ack
    do_instr(8'h0C, 1, 0, 1'b0, 1'b0, 1'b0);  // ADD 12
    do_instr(8'h5D, 0, 1, 1'b0, 1'b0, 1'b0);  // STB 13
    do_instr(8'h73, 0, 0, 1'b1, 1'b0, 1'b0);  // JMP taken
    do_instr(8'h73, 0, 0, 1'b0, 1'b0, 1'b0);  // JMP not taken
    while (pc_m != 15) do_instr(8'h80, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(8'h73, 0, 0, 1'b0, 1'b0, 1'b0);  // not taken at 15 wraps to 0
    while (pc_m != 15) do_instr(8'h9F, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(8'h79, 0, 0, 1'b1, 1'b0, 1'b0);  // taken at 15 overrides wrap
    do_instr(8'h41, 2, 1, 1'b0, 1'b1, 1'b0);  // LDB with run dropped in FETCH
    do_instr(8'h2A, 0, 3, 1'b0, 1'b0, 1'b1);  // reset during MEM wait

    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pc_m  = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_idle", {bus_if.mem_req, busy}, 0);
    end
    run = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 80; n++) begin
      do_instr(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
               ($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_ciclo.md
SEQUENCIADOR_CICLO -- requirements
Module: sequenciador_ciclo

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset; asserts asynchronously, active low.
REQ-004 run  input  1  level; 1 permits fetching of new instructions.
REQ-005 mem_rdata  input  8  memory read data; instruction = {opcode[7:4], imm[3:0]}.
REQ-006 mem_ack  input  1  memory completes the current request in this cycle.
REQ-007 a_zero  input  1  register A equals zero (datapath status).
REQ-008 mem_req  output  1  memory request; held until the acked cycle.
REQ-009 mem_we  output  1  1 = write request, 0 = read request.
REQ-010 mem_addr  output  4  request address.
REQ-011 mem_wsrc  output  2  write-data select: 00 = A, 01 = B, 10 = ALU result.
REQ-012 alu_op  output  2  00 = add, 01 = subtract (A-B).
REQ-013 a_we, b_we  output  1 each  one-cycle register write strobes.
REQ-014 a_src  output  2  A write source: 00 = mem_rdata, 01 = zero-extended imm.
REQ-015 pc  output  4  program counter.
REQ-016 ir  output  8  instruction register.
REQ-017 busy  output  1  state is not IDLE.
REQ-018 instr_done  output  1  one-cycle pulse on instruction retirement.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, MEM and DONE.
REQ-020 IDLE->FETCH when run=1; otherwise remain in IDLE.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack: ir<=mem_rdata, pc<=pc+1 mod 16 (15->0), go to DECODE; otherwise hold all outputs stable.
REQ-022 DECODE (one cycle) by ir[7:4]: 0 ADD, 1 SUB, 2 LDA, 3 STA, 4 LDB, 5 STB -> MEM; 6 LDC -> a_we=1, a_src=01, go to DONE; 7 JMP -> if a_zero, pc<=ir[3:0], go to DONE; 8-15 -> no strobes (NOP), go to DONE.
REQ-023 MEM: mem_req=1, mem_addr=ir[3:0]; hold until mem_ack, then go to DONE.
REQ-024 MEM, ADD/SUB: mem_we=1, mem_wsrc=10, alu_op=00 (ADD) or 01 (SUB).
REQ-025 MEM, STA/STB: mem_we=1, mem_wsrc=00 (STA) or 01 (STB).
REQ-026 MEM, LDA/LDB: mem_we=0; in the mem_ack cycle a_we=1 (LDA) or b_we=1 (LDB), with a_src=00.
REQ-027 DONE: instr_done=1 for one cycle; go to FETCH if run=1, else IDLE.
REQ-028 Outside the states listed above: mem_req=0, mem_we=0, a_we=0, b_we=0; alu_op=00, mem_wsrc=00, a_src=00 whenever not specified.
REQ-029 Latency with zero-wait ack (ack in the req cycle): memory instructions take 4 cycles FETCH->DONE; LDC, JMP and NOP take 3.
REQ-030 run falling mid-instruction SHALL NOT abort it; the instruction retires, then the block enters IDLE.
REQ-031 JMP taken on the instruction at address 15 SHALL override the pc wrap; not taken leaves pc=0.
REQ-032 mem_addr and mem_we SHALL be stable across every cycle of a pending request.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, pc=0, ir=0 and all outputs to 0, including in the middle of a pending request.
REQ-034 After rst_n rises, the first FETCH SHALL occur no earlier than the first clk edge with run=1.

Verification
REQ-035 Reset, run=1, mem_ack tied 1, mem[0]=0x65 (LDC 5) -> FETCH at addr 0, a_we with a_src=01 in DECODE, instr_done 3 cycles after FETCH, pc=1.
REQ-036 mem[1]=0x2A (LDA 10), ack delayed 3 cycles in MEM -> mem_addr=0xA held 4 cycles, a_we only in the ack cycle.
REQ-037 ADD 0x0C, then STB 0x5D -> writes to addr 12 with wsrc=10, alu_op=00; then addr 13 with wsrc=01.
REQ-038 JMP 0x73 with a_zero=1 -> pc=3; with a_zero=0 -> pc=next sequential; JMP at address 15, not taken -> pc=0.
REQ-039 rst_n pulsed low during a MEM wait -> mem_req drops asynchronously, pc=0, busy=0.
REQ-040 run dropped during FETCH -> the instruction completes, instr_done pulses, the block goes to IDLE, no further mem_req.
